// File: rtl/mw93_pkg.sv
// Shared types for the Microwire 93C46-class EEPROM slave:
// opcodes, extended-command subcodes and the command FSM states.
package mw93_pkg;

    typedef enum logic [1:0] {
        OP_EXT   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_ERASE = 2'b11
    } opcode_e;

    // Extended-command subcode lives in the two address MSBs.
    localparam logic [1:0] EXT_EWEN = 2'b11;
    localparam logic [1:0] EXT_EWDS = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OPC   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_RDATA = 3'd3,
        ST_WDATA = 3'd4,
        ST_ARMED = 3'd5,
        ST_BUSY  = 3'd6,
        ST_DONE  = 3'd7
    } state_e;

endpackage

// File: rtl/mw93_mem.sv
// Word store for the EEPROM slave: one write port shared by host preload
// and committed Microwire writes, combinational read port.
module mw93_mem #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [2**ADDR_W];
    logic              we_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [DATA_W-1:0] wdata_s;

    // Preload wins the port; a colliding commit is simply lost.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = wr_addr;
        wdata_s = wr_data;
        if (ld_en) begin
            we_s    = 1'b1;
            waddr_s = ld_addr;
            wdata_s = ld_data;
        end else if (wr_en) begin
            we_s    = 1'b1;
        end else begin
            we_s    = 1'b0;
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[waddr_s] <= wdata_s;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/mw93_slave.sv
// Microwire slave emulating a 64 x 16 serial EEPROM. CS/SK/DI are
// synchronised into clk, SK rising edges drive the command FSM.
module mw93_slave
    import mw93_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int WR_CYCLES   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              sk,
    input  logic              di,
    output logic              do_o,
    output logic              do_oe,
    output logic              busy,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int MAX_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int CNT_W = $clog2(MAX_W);
    localparam int BC_W  = $clog2(WR_CYCLES + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [BC_W-1:0]  BUSY_FIRST = BC_W'(WR_CYCLES - 1);

    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] sk_sync_r;
    logic [SYNC_STAGES-1:0] di_sync_r;
    logic                   sk_prev_r;
    logic                   cs_s;
    logic                   sk_s;
    logic                   di_s;
    logic                   sk_rise_s;

    state_e            state_r, state_n;
    logic [CNT_W-1:0]  cnt_r, cnt_n;
    logic [1:0]        opc_r, opc_n;
    logic [ADDR_W-1:0] addr_r, addr_n;
    logic [ADDR_W-1:0] addr_shift_s;
    logic [DATA_W-1:0] data_r, data_n;
    logic              wen_r, wen_n;
    logic              busy_r, busy_n;
    logic [BC_W-1:0]   bcnt_r, bcnt_n;
    logic              do_r, do_n;
    logic              do_oe_r, do_oe_n;
    logic              commit_s;
    logic [DATA_W-1:0] rd_data_s;

    // Input synchronisers and SK edge history.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync_r <= '0;
            sk_sync_r <= '0;
            di_sync_r <= '0;
            sk_prev_r <= 1'b0;
        end else begin
            cs_sync_r <= {cs_sync_r[SYNC_STAGES-2:0], cs};
            sk_sync_r <= {sk_sync_r[SYNC_STAGES-2:0], sk};
            di_sync_r <= {di_sync_r[SYNC_STAGES-2:0], di};
            sk_prev_r <= sk_s;
        end
    end

    assign cs_s         = cs_sync_r[SYNC_STAGES-1];
    assign sk_s         = sk_sync_r[SYNC_STAGES-1];
    assign di_s         = di_sync_r[SYNC_STAGES-1];
    assign sk_rise_s    = sk_s & ~sk_prev_r;
    assign addr_shift_s = {addr_r[ADDR_W-2:0], di_s};

    // The array is written exactly once, in the first cycle of the busy window.
    assign commit_s = (state_r == ST_BUSY) && busy_r && (bcnt_r == BUSY_FIRST);

    mw93_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .wr_en   (commit_s),
        .wr_addr (addr_r),
        .wr_data (data_r),
        .rd_addr (addr_r),
        .rd_data (rd_data_s)
    );

    // Command FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            opc_r   <= 2'b00;
            addr_r  <= '0;
            data_r  <= '0;
            wen_r   <= 1'b0;
            busy_r  <= 1'b0;
            bcnt_r  <= '0;
            do_r    <= 1'b1;
            do_oe_r <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            opc_r   <= opc_n;
            addr_r  <= addr_n;
            data_r  <= data_n;
            wen_r   <= wen_n;
            busy_r  <= busy_n;
            bcnt_r  <= bcnt_n;
            do_r    <= do_n;
            do_oe_r <= do_oe_n;
        end
    end

    // Next-state and datapath decode; ARMED and BUSY own their cs-low handling.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        opc_n   = opc_r;
        addr_n  = addr_r;
        data_n  = data_r;
        wen_n   = wen_r;
        busy_n  = busy_r;
        bcnt_n  = bcnt_r;
        do_n    = do_r;
        do_oe_n = do_oe_r;

        if (!cs_s && (state_r != ST_ARMED) && (state_r != ST_BUSY)) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            opc_n   = 2'b00;
            addr_n  = '0;
            data_n  = '0;
            do_n    = 1'b1;
            do_oe_n = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    do_oe_n = 1'b0;
                    if (sk_rise_s && di_s) begin
                        state_n = ST_OPC;
                        cnt_n   = '0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_OPC: begin
                    if (sk_rise_s) begin
                        opc_n = {opc_r[0], di_s};
                        if (cnt_r == CNT_W'(1)) begin
                            state_n = ST_ADDR;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_n = ST_OPC;
                    end
                end
                ST_ADDR: begin
                    if (sk_rise_s) begin
                        addr_n = addr_shift_s;
                        if (cnt_r == ADDR_LAST) begin
                            cnt_n = '0;
                            case (opcode_e'(opc_r))
                                OP_READ: begin
                                    state_n = ST_RDATA;
                                    cnt_n   = DATA_LAST;
                                    do_oe_n = 1'b1;
                                    do_n    = 1'b0;
                                end
                                OP_WRITE: begin
                                    state_n = ST_WDATA;
                                end
                                OP_ERASE: begin
                                    state_n = ST_ARMED;
                                    data_n  = '1;
                                end
                                OP_EXT: begin
                                    state_n = ST_DONE;
                                    if (addr_shift_s[ADDR_W-1 -: 2] == EXT_EWEN) begin
                                        wen_n = 1'b1;
                                    end else if (addr_shift_s[ADDR_W-1 -: 2] == EXT_EWDS) begin
                                        wen_n = 1'b0;
                                    end else begin
                                        wen_n = wen_r;
                                    end
                                end
                                default: begin
                                    state_n = ST_DONE;
                                end
                            endcase
                        end else begin
                            cnt_n = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_n = ST_ADDR;
                    end
                end
                ST_RDATA: begin
                    if (sk_rise_s) begin
                        do_n = rd_data_s[cnt_r];
                        if (cnt_r == '0) begin
                            cnt_n  = DATA_LAST;
                            addr_n = addr_r + ADDR_W'(1);
                        end else begin
                            cnt_n = cnt_r - CNT_W'(1);
                        end
                    end else begin
                        state_n = ST_RDATA;
                    end
                end
                ST_WDATA: begin
                    if (sk_rise_s) begin
                        data_n = {data_r[DATA_W-2:0], di_s};
                        if (cnt_r == DATA_LAST) begin
                            state_n = ST_ARMED;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_n = ST_WDATA;
                    end
                end
                ST_ARMED: begin
                    if (!cs_s && wen_r) begin
                        state_n = ST_BUSY;
                        busy_n  = 1'b1;
                        bcnt_n  = BUSY_FIRST;
                        do_n    = 1'b0;
                        do_oe_n = 1'b0;
                    end else if (!cs_s) begin
                        state_n = ST_IDLE;
                        do_n    = 1'b1;
                        do_oe_n = 1'b0;
                    end else begin
                        state_n = ST_ARMED;
                    end
                end
                ST_BUSY: begin
                    if (busy_r) begin
                        do_oe_n = cs_s;
                        if (bcnt_r == '0) begin
                            busy_n = 1'b0;
                            do_n   = 1'b1;
                        end else begin
                            bcnt_n = bcnt_r - BC_W'(1);
                            do_n   = 1'b0;
                        end
                    end else if (!cs_s) begin
                        state_n = ST_IDLE;
                        do_n    = 1'b1;
                        do_oe_n = 1'b0;
                    end else begin
                        do_n    = 1'b1;
                        do_oe_n = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_n = ST_DONE;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    assign do_o  = do_r;
    assign do_oe = do_oe_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_mw93_slave.sv
// Directed bench for mw93_slave: a preload/read-back table plus
// hand-written Microwire sequences for write, erase, abort and reset cases.
module tb_mw93_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0;
    logic        sk = 1'b0;
    logic        di = 1'b0;
    logic        do_o;
    logic        do_oe;
    logic        busy;
    logic        ld_en = 1'b0;
    logic [5:0]  ld_addr = 6'd0;
    logic [15:0] ld_data = 16'h0000;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [4];

    mw93_slave dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .sk      (sk),
        .di      (di),
        .do_o    (do_o),
        .do_oe   (do_oe),
        .busy    (busy),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cs  = 1'b0;
        sk  = 1'b0;
        di  = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic sk_bit(input logic d);
        di = d;
        tick(4);
        sk = 1'b1;
        tick(6);
        sk = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [5:0] a);
        cs = 1'b1;
        tick(4);
        sk_bit(1'b1);
        for (int i = 1; i >= 0; i--) sk_bit(op[i]);
        for (int i = 5; i >= 0; i--) sk_bit(a[i]);
    endtask

    task automatic send_word(input logic [15:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) sk_bit(w[15-i]);
    endtask

    task automatic read_word(output logic [15:0] w);
        w = 16'h0000;
        for (int i = 15; i >= 0; i--) begin
            sk_bit(1'b0);
            w[i] = do_o;
        end
    endtask

    task automatic cs_drop();
        cs = 1'b0;
        di = 1'b0;
        tick(6);
    endtask

    task automatic preload(input logic [5:0] a, input logic [15:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        tick(1);
        ld_en   = 1'b0;
    endtask

    task automatic wait_busy(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (busy) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (!busy) break;
            tick(1);
        end
    endtask

    task automatic read_check(input string name, input logic [5:0] a, input logic [15:0] exp);
        logic [15:0] w;
        send_cmd(2'b10, a);
        check({name, "_dummy"}, {30'd0, do_oe, do_o}, 32'h2);
        read_word(w);
        check(name, {16'd0, w}, {16'd0, exp});
        cs_drop();
    endtask

    initial begin
        logic [15:0] w;
        bit          seen;
        int          n;

        vecs[0] = '{6'd1,  16'h8001, 16'h8001};
        vecs[1] = '{6'd42, 16'h5AA5, 16'h5AA5};
        vecs[2] = '{6'd32, 16'hFFFF, 16'hFFFF};
        vecs[3] = '{6'd17, 16'h0001, 16'h0001};

        do_reset();
        check("rst_do",    {31'd0, do_o},  32'd1);
        check("rst_do_oe", {31'd0, do_oe}, 32'd0);
        check("rst_busy",  {31'd0, busy},  32'd0);

        // Table: preload then read back over the serial interface.
        for (int i = 0; i < 4; i++) begin
            preload(vecs[i].addr, vecs[i].data);
            read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // 1: EWEN, WRITE 5 = A55A, busy window, read back.
        send_cmd(2'b00, 6'b110000);
        cs_drop();
        send_cmd(2'b01, 6'd5);
        send_word(16'hA55A, 16);
        cs = 1'b0;
        di = 1'b0;
        wait_busy(20, seen);
        check("t1_busy_rise", {31'd0, seen}, 32'd1);
        cs = 1'b1;
        n  = 0;
        while (busy && n < 200) begin
            n++;
            if (n == 10) check("t1_busy_do", {30'd0, do_oe, do_o}, 32'h2);
            tick(1);
        end
        check("t1_busy_len", n, 32'd64);
        tick(2);
        check("t1_ready_do", {30'd0, do_oe, do_o}, 32'h3);
        cs_drop();
        check("t1_idle_oe", {31'd0, do_oe}, 32'd0);
        read_check("t1_read", 6'd5, 16'hA55A);

        // 2: no EWEN after reset, WRITE must not commit.
        do_reset();
        preload(6'd3, 16'h0000);
        send_cmd(2'b01, 6'd3);
        send_word(16'h1234, 16);
        cs = 1'b0;
        wait_busy(40, seen);
        check("t2_no_busy", {31'd0, seen}, 32'd0);
        read_check("t2_read", 6'd3, 16'h0000);

        // 3: sequential read wraps 63 -> 0.
        preload(6'd63, 16'hBEEF);
        preload(6'd0,  16'hCAFE);
        send_cmd(2'b10, 6'd63);
        read_word(w);
        check("t3_w63", {16'd0, w}, 32'h0000BEEF);
        read_word(w);
        check("t3_w0", {16'd0, w}, 32'h0000CAFE);
        cs_drop();

        // 4: ERASE with and without write enable.
        preload(6'd10, 16'h0F0F);
        send_cmd(2'b00, 6'b110000);
        cs_drop();
        send_cmd(2'b11, 6'd10);
        cs = 1'b0;
        wait_busy(20, seen);
        check("t4_erase_busy", {31'd0, seen}, 32'd1);
        wait_idle(200);
        tick(2);
        read_check("t4_erased", 6'd10, 16'hFFFF);
        preload(6'd10, 16'h0F0F);
        send_cmd(2'b00, 6'b000000);
        cs_drop();
        send_cmd(2'b11, 6'd10);
        cs = 1'b0;
        wait_busy(40, seen);
        check("t4_ewds_busy", {31'd0, seen}, 32'd0);
        read_check("t4_kept", 6'd10, 16'h0F0F);

        // 5: WRITE aborted after 9 data bits.
        preload(6'd7, 16'h7777);
        send_cmd(2'b00, 6'b110000);
        cs_drop();
        send_cmd(2'b01, 6'd7);
        send_word(16'h1111, 9);
        cs = 1'b0;
        wait_busy(40, seen);
        check("t5_no_busy", {31'd0, seen}, 32'd0);
        read_check("t5_read", 6'd7, 16'h7777);

        // 6: reset in the 10th busy cycle clears busy, DO drive and latch.
        send_cmd(2'b00, 6'b110000);
        cs_drop();
        send_cmd(2'b01, 6'd20);
        send_word(16'h4242, 16);
        cs = 1'b0;
        wait_busy(20, seen);
        check("t6_busy_rise", {31'd0, seen}, 32'd1);
        cs = 1'b1;
        tick(9);
        check("t6_pre_oe", {31'd0, do_oe}, 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6_busy_clr", {31'd0, busy},  32'd0);
        check("t6_oe_clr",   {31'd0, do_oe}, 32'd0);
        cs_drop();
        send_cmd(2'b01, 6'd21);
        send_word(16'h9999, 16);
        cs = 1'b0;
        wait_busy(40, seen);
        check("t6_latch_clr", {31'd0, seen}, 32'd0);
        tick(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
